// File: rtl/uart_pkg.sv
// Shared register map, init operand bundle and sequencer state encoding for the UART register sequencer.
// The SCR self-check states exist only when UART_SEQ_SCR_CHECK_EN is defined.
package uart_pkg;

  localparam logic [2:0] ADDR_THR_DLL = 3'd0;
  localparam logic [2:0] ADDR_IER_DLM = 3'd1;
  localparam logic [2:0] ADDR_FCR     = 3'd2;
  localparam logic [2:0] ADDR_LCR     = 3'd3;
  localparam logic [2:0] ADDR_LSR     = 3'd5;
  localparam logic [2:0] ADDR_SCR     = 3'd7;

  localparam int         LCR_DLAB_BIT = 7;
  localparam logic [7:0] DLAB_MASK    = 8'(1 << LCR_DLAB_BIT);
  localparam logic [7:0] SCR_PATTERN  = 8'hA5;

  typedef enum logic [3:0] {
    INIT_LCR_DLAB,
    INIT_DLL,
    INIT_DLM,
    INIT_LCR,
    INIT_FCR,
`ifdef UART_SEQ_SCR_CHECK_EN
    INIT_SCR_WR,
    INIT_SCR_RD0,
    INIT_SCR_RD1,
    INIT_SCR_RD2,
`endif
    ARB_IDLE,
    WR,
    RD0,
    RD1,
    RD2
  } seq_state_e;

  typedef struct packed {
    logic [15:0] div;
    logic [7:0]  lcr;
    logic [7:0]  fcr;
  } init_ops_t;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-requester round-robin arbiter: grants the sole requester, or on a tie the one not granted last.
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_b;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_b <= 1'b1;
    else if (update) last_b <= gnt[1];
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_b ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_reg_sequencer.sv
// Programs regs_uart at reset / on cfg_start_i, then round-robins two requesters onto its register port.
// Optional SCR write/readback self-check at the end of init: define UART_SEQ_SCR_CHECK_EN.
module uart_reg_sequencer
  import uart_pkg::*;
#(
  parameter logic [15:0] DIV_DEFAULT = 16'd27,
  parameter logic [7:0]  LCR_DEFAULT = 8'h03,
  parameter logic [7:0]  FCR_DEFAULT = 8'h87
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start_i,
  input  logic [15:0] cfg_div_i,
  input  logic [7:0]  cfg_lcr_i,
  input  logic [7:0]  cfg_fcr_i,
  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic [2:0]  a_addr_i,
  input  logic [7:0]  a_wdata_i,
  output logic        a_ack_o,
  output logic [7:0]  a_rdata_o,
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic [2:0]  b_addr_i,
  input  logic [7:0]  b_wdata_i,
  output logic        b_ack_o,
  output logic [7:0]  b_rdata_o,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  output logic [2:0]  reg_addr_o,
  output logic [7:0]  reg_din_o,
  input  logic [7:0]  reg_dout_i,
  output logic        init_done_o,
  output logic        busy_o
`ifdef UART_SEQ_SCR_CHECK_EN
  ,
  output logic        init_err_o
`endif
);

  localparam init_ops_t OPS_DEFAULT = {DIV_DEFAULT, LCR_DEFAULT, FCR_DEFAULT};
`ifdef UART_SEQ_SCR_CHECK_EN
  localparam seq_state_e INIT_LAST = INIT_SCR_RD2;
`else
  localparam seq_state_e INIT_LAST = INIT_FCR;
`endif

  seq_state_e state, next_state;
  init_ops_t  ops_q, cfg_q;
  logic       cfg_pend;
  logic       txn_b;
  logic [2:0] txn_addr;
  logic [7:0] txn_wdata;
  logic [7:0] a_rdata_q, b_rdata_q;
  logic       init_done_q;
  logic [1:0] gnt;
  logic       grant_take, init_begin;
  logic       sel_we;
  logic [2:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       wr, rd;
  logic [2:0] addr;
  logic [7:0] din;

  // A pending reconfiguration always beats port requests in ARB_IDLE.
  assign init_begin = (state == ARB_IDLE) && cfg_pend;
  assign grant_take = (state == ARB_IDLE) && !cfg_pend && (a_req_i || b_req_i);
  assign sel_we     = gnt[1] ? b_we_i    : a_we_i;
  assign sel_addr   = gnt[1] ? b_addr_i  : a_addr_i;
  assign sel_wdata  = gnt[1] ? b_wdata_i : a_wdata_i;

  uart_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({b_req_i, a_req_i}),
    .update (grant_take),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT_LCR_DLAB;
    else     state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      INIT_LCR_DLAB: next_state = INIT_DLL;
      INIT_DLL:      next_state = INIT_DLM;
      INIT_DLM:      next_state = INIT_LCR;
      INIT_LCR:      next_state = INIT_FCR;
`ifdef UART_SEQ_SCR_CHECK_EN
      INIT_FCR:      next_state = INIT_SCR_WR;
      INIT_SCR_WR:   next_state = INIT_SCR_RD0;
      INIT_SCR_RD0:  next_state = INIT_SCR_RD1;
      INIT_SCR_RD1:  next_state = INIT_SCR_RD2;
      INIT_SCR_RD2:  next_state = ARB_IDLE;
`else
      INIT_FCR:      next_state = ARB_IDLE;
`endif
      ARB_IDLE: begin
        if (init_begin)      next_state = INIT_LCR_DLAB;
        else if (grant_take) next_state = sel_we ? WR : RD0;
      end
      WR:            next_state = ARB_IDLE;
      RD0:           next_state = RD1;
      RD1:           next_state = RD2;
      RD2:           next_state = ARB_IDLE;
      default:       next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    wr   = 1'b0;
    rd   = 1'b0;
    addr = 3'd0;
    din  = 8'd0;
    case (state)
      INIT_LCR_DLAB: begin wr = 1'b1; addr = ADDR_LCR;     din = ops_q.lcr | DLAB_MASK;  end
      INIT_DLL:      begin wr = 1'b1; addr = ADDR_THR_DLL; din = ops_q.div[7:0];         end
      INIT_DLM:      begin wr = 1'b1; addr = ADDR_IER_DLM; din = ops_q.div[15:8];        end
      INIT_LCR:      begin wr = 1'b1; addr = ADDR_LCR;     din = ops_q.lcr & ~DLAB_MASK; end
      INIT_FCR:      begin wr = 1'b1; addr = ADDR_FCR;     din = ops_q.fcr;              end
`ifdef UART_SEQ_SCR_CHECK_EN
      INIT_SCR_WR:   begin wr = 1'b1; addr = ADDR_SCR;     din = SCR_PATTERN;            end
      INIT_SCR_RD0:  begin rd = 1'b1; addr = ADDR_SCR;                                   end
      INIT_SCR_RD1,
      INIT_SCR_RD2:  addr = ADDR_SCR;
`endif
      WR:            begin wr = 1'b1; addr = txn_addr;     din = txn_wdata;              end
      RD0:           begin rd = 1'b1; addr = txn_addr;                                   end
      RD1, RD2:      addr = txn_addr;
      default:       ;
    endcase
  end

  // Reset parks the FSM in the first init state; keep the bus quiet until it is released.
  assign reg_wr_o    = wr & ~rst;
  assign reg_rd_o    = rd & ~rst;
  assign reg_addr_o  = rst ? 3'd0 : addr;
  assign reg_din_o   = rst ? 8'd0 : din;
  assign busy_o      = ~rst & (state != ARB_IDLE);
  assign init_done_o = init_done_q;

  assign a_ack_o   = ((state == WR) || (state == RD2)) && !txn_b;
  assign b_ack_o   = ((state == WR) || (state == RD2)) &&  txn_b;
  assign a_rdata_o = ((state == RD2) && !txn_b) ? reg_dout_i : a_rdata_q;
  assign b_rdata_o = ((state == RD2) &&  txn_b) ? reg_dout_i : b_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q       <= OPS_DEFAULT;
      cfg_q       <= OPS_DEFAULT;
      cfg_pend    <= 1'b0;
      txn_b       <= 1'b0;
      txn_addr    <= 3'd0;
      txn_wdata   <= 8'd0;
      a_rdata_q   <= 8'd0;
      b_rdata_q   <= 8'd0;
      init_done_q <= 1'b0;
    end else begin
      if (init_begin) begin
        ops_q       <= cfg_q;
        cfg_pend    <= 1'b0;
        init_done_q <= 1'b0;
      end
      // A pulse on the same edge as init_begin stays pending and reruns init afterwards.
      if (cfg_start_i) begin
        cfg_q    <= {cfg_div_i, cfg_lcr_i, cfg_fcr_i};
        cfg_pend <= 1'b1;
      end
      if (grant_take) begin
        txn_b     <= gnt[1];
        txn_addr  <= sel_addr;
        txn_wdata <= sel_wdata;
      end
      if (state == RD2) begin
        if (txn_b) b_rdata_q <= reg_dout_i;
        else       a_rdata_q <= reg_dout_i;
      end
      if (state == INIT_LAST) init_done_q <= 1'b1;
    end
  end

`ifdef UART_SEQ_SCR_CHECK_EN
  logic init_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        init_err_q <= 1'b0;
    else if (init_begin)            init_err_q <= 1'b0;
    else if (state == INIT_SCR_RD2) init_err_q <= (reg_dout_i != SCR_PATTERN);
  end

  assign init_err_o = init_err_q;
`endif

endmodule

// File: tb/tb_uart_reg_sequencer.sv
// Directed bench for uart_reg_sequencer with a small 2-cycle-latency register block model.
// Define UART_SEQ_SCR_CHECK_EN for both RTL and bench to cover the SCR self-check.
module tb_uart_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start_i = 1'b0;
  logic [15:0] cfg_div_i = 16'd0;
  logic [7:0]  cfg_lcr_i = 8'd0;
  logic [7:0]  cfg_fcr_i = 8'd0;
  logic        a_req_i = 1'b0, a_we_i = 1'b0;
  logic [2:0]  a_addr_i = 3'd0;
  logic [7:0]  a_wdata_i = 8'd0;
  logic        b_req_i = 1'b0, b_we_i = 1'b0;
  logic [2:0]  b_addr_i = 3'd0;
  logic [7:0]  b_wdata_i = 8'd0;
  logic        a_ack_o, b_ack_o;
  logic [7:0]  a_rdata_o, b_rdata_o;
  logic        reg_wr_o, reg_rd_o;
  logic [2:0]  reg_addr_o;
  logic [7:0]  reg_din_o, reg_dout_i;
  logic        init_done_o, busy_o;
`ifdef UART_SEQ_SCR_CHECK_EN
  logic        init_err_o;
  logic        exp_init_err = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  uart_reg_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_start_i (cfg_start_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_lcr_i   (cfg_lcr_i),
    .cfg_fcr_i   (cfg_fcr_i),
    .a_req_i     (a_req_i),
    .a_we_i      (a_we_i),
    .a_addr_i    (a_addr_i),
    .a_wdata_i   (a_wdata_i),
    .a_ack_o     (a_ack_o),
    .a_rdata_o   (a_rdata_o),
    .b_req_i     (b_req_i),
    .b_we_i      (b_we_i),
    .b_addr_i    (b_addr_i),
    .b_wdata_i   (b_wdata_i),
    .b_ack_o     (b_ack_o),
    .b_rdata_o   (b_rdata_o),
    .reg_wr_o    (reg_wr_o),
    .reg_rd_o    (reg_rd_o),
    .reg_addr_o  (reg_addr_o),
    .reg_din_o   (reg_din_o),
    .reg_dout_i  (reg_dout_i),
    .init_done_o (init_done_o),
    .busy_o      (busy_o)
`ifdef UART_SEQ_SCR_CHECK_EN
    ,
    .init_err_o  (init_err_o)
`endif
  );

  always #5 clk = ~clk;

  // Register block model: plain storage, read data appears two cycles after the rd strobe.
  logic [7:0] mem [8];
  logic [7:0] rd_stage = 8'd0, dout_q = 8'd0;
  bit         force_zero = 1'b0;

  initial for (int i = 0; i < 8; i++) mem[i] = 8'd0;

  always @(posedge clk) begin
    if (reg_wr_o) mem[reg_addr_o] <= reg_din_o;
    rd_stage <= mem[reg_addr_o];
    dout_q   <= rd_stage;
  end

  assign reg_dout_i = force_zero ? 8'd0 : dout_q;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } init_vec_t;

  typedef struct {
    logic       port_b;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } txn_vec_t;

  init_vec_t  init_def [5];
  init_vec_t  init_cfg [5];
  txn_vec_t   txns     [8];
  logic [7:0] last_a_rdata = 8'd0, last_b_rdata = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic check_init(input bit use_cfg);
    int        wait_n = 0;
    init_vec_t v;
    while (!(reg_wr_o && reg_addr_o == 3'd3 && reg_din_o[7]) && wait_n < 20) begin
      next_cyc();
      wait_n++;
    end
    check("init_start_seen", 32'(wait_n < 20), 1);
    check("init_done_low_during_init", init_done_o, 0);
    for (int i = 0; i < 5; i++) begin
      v = use_cfg ? init_cfg[i] : init_def[i];
      check($sformatf("init%0d_wr", i), reg_wr_o, 1);
      check($sformatf("init%0d_rd", i), reg_rd_o, 0);
      check($sformatf("init%0d_addr", i), reg_addr_o, v.addr);
      check($sformatf("init%0d_din", i), reg_din_o, v.data);
      check($sformatf("init%0d_busy", i), busy_o, 1);
      next_cyc();
    end
`ifdef UART_SEQ_SCR_CHECK_EN
    check("scr_wr", {reg_wr_o, reg_rd_o, reg_addr_o, reg_din_o}, {2'b10, 3'd7, 8'hA5});
    next_cyc();
    check("scr_rd0", {reg_wr_o, reg_rd_o, reg_addr_o}, {2'b01, 3'd7});
    next_cyc();
    check("scr_rd1", {reg_wr_o, reg_rd_o, reg_addr_o}, {2'b00, 3'd7});
    next_cyc();
    check("scr_rd2", {reg_wr_o, reg_rd_o, reg_addr_o}, {2'b00, 3'd7});
    next_cyc();
    check("init_err", init_err_o, exp_init_err);
`endif
    check("init_done_set", init_done_o, 1);
    check("idle_after_init", busy_o, 0);
  endtask

  task automatic run_txn(input int idx, input txn_vec_t v);
    int         lat = 0;
    logic       ack = 1'b0, other_ack;
    logic [7:0] rdata, exp_rdata;
    if (v.port_b) begin
      b_req_i = 1'b1; b_we_i = v.we; b_addr_i = v.addr; b_wdata_i = v.wdata;
    end else begin
      a_req_i = 1'b1; a_we_i = v.we; a_addr_i = v.addr; a_wdata_i = v.wdata;
    end
    while (!ack && lat < 8) begin
      next_cyc();
      lat++;
      if (lat == 1 && !v.we)
        check($sformatf("txn%0d_rd0_strobe", idx), {reg_wr_o, reg_rd_o, reg_addr_o}, {2'b01, v.addr});
      ack = v.port_b ? b_ack_o : a_ack_o;
    end
    other_ack = v.port_b ? a_ack_o : b_ack_o;
    rdata     = v.port_b ? b_rdata_o : a_rdata_o;
    check($sformatf("txn%0d_latency", idx), lat, v.we ? 1 : 3);
    check($sformatf("txn%0d_other_ack", idx), other_ack, 0);
    if (v.we) begin
      check($sformatf("txn%0d_wr_strobe", idx), {reg_wr_o, reg_rd_o, reg_addr_o, reg_din_o},
            {2'b10, v.addr, v.wdata});
      exp_rdata = v.port_b ? last_b_rdata : last_a_rdata;
    end else begin
      check($sformatf("txn%0d_rd2_addr", idx), {reg_rd_o, reg_addr_o}, {1'b0, v.addr});
      exp_rdata = v.exp_rdata;
      if (v.port_b) last_b_rdata = v.exp_rdata;
      else          last_a_rdata = v.exp_rdata;
    end
    check($sformatf("txn%0d_rdata", idx), rdata, exp_rdata);
    if (v.port_b) b_req_i = 1'b0;
    else          a_req_i = 1'b0;
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acks;
    int budget;
    logic exp_b;

    init_def[0] = '{3'd3, 8'h83};
    init_def[1] = '{3'd0, 8'h1B};
    init_def[2] = '{3'd1, 8'h00};
    init_def[3] = '{3'd3, 8'h03};
    init_def[4] = '{3'd2, 8'h87};
    init_cfg[0] = '{3'd3, 8'h9B};
    init_cfg[1] = '{3'd0, 8'h45};
    init_cfg[2] = '{3'd1, 8'h01};
    init_cfg[3] = '{3'd3, 8'h1B};
    init_cfg[4] = '{3'd2, 8'h07};

    txns[0] = '{1'b0, 1'b1, 3'd7, 8'h5A, 8'h00};
    txns[1] = '{1'b0, 1'b0, 3'd7, 8'h00, 8'h5A};
    txns[2] = '{1'b1, 1'b1, 3'd4, 8'hC3, 8'h00};
    txns[3] = '{1'b1, 1'b0, 3'd4, 8'h00, 8'hC3};
    txns[4] = '{1'b0, 1'b1, 3'd6, 8'h0F, 8'h00};
    txns[5] = '{1'b1, 1'b0, 3'd6, 8'h00, 8'h0F};
    txns[6] = '{1'b0, 1'b0, 3'd4, 8'h00, 8'hC3};
    txns[7] = '{1'b1, 1'b0, 3'd7, 8'h00, 8'h5A};

    // Reset state, then the default init sequence.
    next_cyc();
    next_cyc();
    check("rst_outputs", {reg_wr_o, reg_rd_o, reg_addr_o, reg_din_o, a_ack_o, b_ack_o},
          {2'b00, 3'd0, 8'd0, 2'b00});
    check("rst_status", {init_done_o, busy_o, a_rdata_o, b_rdata_o}, {2'b00, 16'd0});
    rst = 1'b0;
    #1;
    check_init(1'b0);

    for (int i = 0; i < 8; i++) run_txn(i, txns[i]);

    // Both ports read continuously; B was granted last, so A wins the first tie.
    a_we_i = 1'b0; a_addr_i = 3'd7;
    b_we_i = 1'b0; b_addr_i = 3'd4;
    a_req_i = 1'b1; b_req_i = 1'b1;
    n_acks = 0; budget = 0; exp_b = 1'b0;
    while (n_acks < 8 && budget < 60) begin
      next_cyc();
      budget++;
      check("rr_no_strobe_overlap", 32'(reg_wr_o && reg_rd_o), 0);
      if (a_ack_o || b_ack_o) begin
        n_acks++;
        check($sformatf("rr_ack%0d_port", n_acks), {a_ack_o, b_ack_o}, exp_b ? 2'b01 : 2'b10);
        check($sformatf("rr_ack%0d_rdata", n_acks), exp_b ? b_rdata_o : a_rdata_o,
              exp_b ? 8'hC3 : 8'h5A);
        if (n_acks >= 7) begin
          if (b_ack_o) b_req_i = 1'b0;
          else         a_req_i = 1'b0;
        end
        exp_b = ~exp_b;
      end
    end
    check("rr_ack_count", n_acks, 8);
    a_req_i = 1'b0; b_req_i = 1'b0;
    next_cyc();
    last_a_rdata = 8'h5A;
    last_b_rdata = 8'hC3;

    // Reconfiguration requested while B's read is in flight: B completes first.
    b_we_i = 1'b0; b_addr_i = 3'd4; b_req_i = 1'b1;
    cfg_div_i = 16'h0145; cfg_lcr_i = 8'h1B; cfg_fcr_i = 8'h07;
    next_cyc();
    check("cfg_rd0", reg_rd_o, 1);
    cfg_start_i = 1'b1;
    next_cyc();
    cfg_start_i = 1'b0;
    check("cfg_rd1_no_ack", b_ack_o, 0);
    next_cyc();
    check("cfg_b_ack", {a_ack_o, b_ack_o}, 2'b01);
    check("cfg_b_rdata", b_rdata_o, 8'hC3);
    check("cfg_not_init_yet", reg_wr_o, 0);
    b_req_i = 1'b0;
    next_cyc();
    check_init(1'b1);

    // Reset during RD1 aborts with no ack; default init reruns.
    a_we_i = 1'b0; a_addr_i = 3'd7; a_req_i = 1'b1;
    next_cyc();
    next_cyc();
    check("abort_in_rd1", {reg_wr_o, reg_rd_o, reg_addr_o}, {2'b00, 3'd7});
    rst = 1'b1;
    #1;
    check("abort_outputs", {a_ack_o, b_ack_o, reg_wr_o, reg_rd_o, busy_o, init_done_o}, 6'd0);
    a_req_i = 1'b0;
    next_cyc();
    check("abort_no_ack", a_ack_o, 0);
    rst = 1'b0;
    #1;
    check_init(1'b0);

`ifdef UART_SEQ_SCR_CHECK_EN
    // SCR readback forced wrong: error flag set, init still completes.
    force_zero   = 1'b1;
    exp_init_err = 1'b1;
    cfg_div_i = 16'd27; cfg_lcr_i = 8'h03; cfg_fcr_i = 8'h87;
    cfg_start_i = 1'b1;
    next_cyc();
    cfg_start_i = 1'b0;
    check_init(1'b0);
    force_zero = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
